// File: rtl/core_pkg.sv
// Shared definitions for the core_seq instruction sequencer: opcodes,
// instruction field positions, FSM state encoding and the default reset PC.
package core_pkg;

    localparam logic [7:0] RESET_PC_DEF = 8'd10;

    // Instruction field positions: [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RA_MSB  = 7;
    localparam int RA_LSB  = 4;
    localparam int RB_MSB  = 3;
    localparam int RB_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes 0x0-0x7 are ALU operations selected by opcode[2:0]
    localparam logic [3:0] OPC_JMP  = 4'h8;
    localparam logic [3:0] OPC_BEQZ = 4'h9;
    localparam logic [3:0] OPC_HALT = 4'hF;

    localparam int ALU_SEL_W = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Sequential PC increment, wrapping 255 -> 0
    function automatic logic [7:0] pc_inc(input logic [7:0] pc);
        return pc + 8'd1;
    endfunction

endpackage

// File: rtl/core_decode.sv
// Combinational instruction decoder for core_seq.
// Branch opcodes are recognised only when CORE_SEQ_BRANCH_EN is defined;
// otherwise JMP/BEQZ fall through as NOPs.
module core_decode
    import core_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic [INSTR_W-1:0]   ir,
    output logic [ALU_SEL_W-1:0] alu_func,
    output logic                 is_alu,
    output logic                 is_jmp,
    output logic                 is_beqz,
    output logic                 is_halt,
    output logic [3:0]           rd,
    output logic [3:0]           ra,
    output logic [3:0]           rb,
    output logic [7:0]           imm8
);

    logic [3:0] opcode_s;

    // Field extraction and opcode classification
    always_comb begin
        opcode_s = ir[OPC_MSB:OPC_LSB];
        rd       = ir[RD_MSB:RD_LSB];
        ra       = ir[RA_MSB:RA_LSB];
        rb       = ir[RB_MSB:RB_LSB];
        imm8     = ir[IMM_MSB:IMM_LSB];
        is_alu   = (opcode_s[3] == 1'b0);
        is_halt  = (opcode_s == OPC_HALT);
        if (opcode_s[3] == 1'b0) begin
            alu_func = opcode_s[ALU_SEL_W-1:0];
        end else begin
            alu_func = {ALU_SEL_W{1'b0}};
        end
`ifdef CORE_SEQ_BRANCH_EN
        is_jmp  = (opcode_s == OPC_JMP);
        is_beqz = (opcode_s == OPC_BEQZ);
`else
        is_jmp  = 1'b0;
        is_beqz = 1'b0;
`endif
    end

endmodule

// File: rtl/core_seq.sv
// core_seq: multi-cycle instruction sequencer (IDLE/FETCH/DECODE/EXEC/WB/HALT).
// Optional feature macro: CORE_SEQ_BRANCH_EN enables JMP and BEQZ; without it
// opcodes 0x8/0x9 execute as NOP and no branch compare exists.
// The ALU and register-file strobes are gated by clk_en so they only fire on
// cycles where the whole core actually advances.
module core_seq
    import core_pkg::*;
#(
    parameter logic [7:0] RESET_PC   = RESET_PC_DEF,
    parameter int         INSTR_W    = 16,
    parameter int         ALU_FUNC_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    output logic                  imem_req,
    output logic [7:0]            imem_addr,
    input  logic                  imem_ack,
    input  logic [INSTR_W-1:0]    imem_rdata,
    output logic [3:0]            regfile_read_addr_a,
    output logic [3:0]            regfile_read_addr_b,
    input  logic [7:0]            regfile_read_data_a,
    output logic [3:0]            regfile_write_addr,
    output logic                  regfile_write_enable,
    output logic [ALU_FUNC_W-1:0] alu_func,
    output logic                  alu_clk_en,
    output logic [7:0]            pc,
    output logic                  halted
);

    state_t               state_r;
    state_t               state_next_s;
    logic [7:0]           pc_r;
    logic [7:0]           pc_next_s;
    logic [INSTR_W-1:0]   ir_r;
    logic                 imem_req_r;
    logic                 alu_arm_r;
    logic                 wb_arm_r;
    logic                 halted_r;

    logic [ALU_SEL_W-1:0] alu_sel_s;
    logic                 is_alu_s;
    logic                 is_jmp_s;
    logic                 is_beqz_s;
    logic                 is_halt_s;
    logic [3:0]           rd_s;
    logic [3:0]           ra_s;
    logic [3:0]           rb_s;
    logic [7:0]           imm8_s;

    core_decode #(
        .INSTR_W (INSTR_W)
    ) u_decode (
        .ir       (ir_r),
        .alu_func (alu_sel_s),
        .is_alu   (is_alu_s),
        .is_jmp   (is_jmp_s),
        .is_beqz  (is_beqz_s),
        .is_halt  (is_halt_s),
        .rd       (rd_s),
        .ra       (ra_s),
        .rb       (rb_s),
        .imm8     (imm8_s)
    );

    // Next-state logic; nothing moves while clk_en is low
    always_comb begin
        state_next_s = state_r;
        if (clk_en) begin
            case (state_r)
                S_IDLE:   state_next_s = S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        state_next_s = S_DECODE;
                    end else begin
                        state_next_s = S_FETCH;
                    end
                end
                S_DECODE: state_next_s = S_EXEC;
                S_EXEC: begin
                    if (is_halt_s) begin
                        state_next_s = S_HALT;
                    end else begin
                        state_next_s = S_WB;
                    end
                end
                S_WB:     state_next_s = S_FETCH;
                S_HALT:   state_next_s = S_HALT;
                default:  state_next_s = S_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

`ifdef CORE_SEQ_BRANCH_EN
    // PC update in WB: jump, taken branch on zero operand, or sequential
    always_comb begin
        pc_next_s = pc_r;
        if (clk_en && (state_r == S_WB)) begin
            if (is_jmp_s) begin
                pc_next_s = imm8_s;
            end else if (is_beqz_s && (regfile_read_data_a == 8'd0)) begin
                pc_next_s = imm8_s;
            end else begin
                pc_next_s = pc_inc(pc_r);
            end
        end else begin
            pc_next_s = pc_r;
        end
    end
`else
    // Branch operands are not consumed when branching is compiled out
    logic unused_branch_s;
    assign unused_branch_s = ^{regfile_read_data_a, imm8_s, is_jmp_s, is_beqz_s};

    // PC update in WB: always sequential without branch support
    always_comb begin
        pc_next_s = pc_r;
        if (clk_en && (state_r == S_WB)) begin
            pc_next_s = pc_inc(pc_r);
        end else begin
            pc_next_s = pc_r;
        end
    end
`endif

    // State, PC, IR and registered output qualifiers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            pc_r       <= RESET_PC;
            ir_r       <= {INSTR_W{1'b0}};
            imem_req_r <= 1'b0;
            alu_arm_r  <= 1'b0;
            wb_arm_r   <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            if (clk_en && (state_r == S_FETCH) && imem_ack) begin
                ir_r <= imem_rdata;
            end else begin
                ir_r <= ir_r;
            end
            imem_req_r <= (state_next_s == S_FETCH);
            alu_arm_r  <= (state_next_s == S_EXEC) && is_alu_s;
            wb_arm_r   <= (state_next_s == S_WB) && is_alu_s;
            halted_r   <= (state_next_s == S_HALT);
        end
    end

    assign imem_req             = imem_req_r;
    assign imem_addr            = pc_r;
    assign pc                   = pc_r;
    assign halted               = halted_r;
    assign regfile_read_addr_a  = ra_s;
    assign regfile_read_addr_b  = rb_s;
    assign regfile_write_addr   = rd_s;
    assign alu_func             = ALU_FUNC_W'(alu_sel_s);
    assign alu_clk_en           = alu_arm_r & clk_en;
    assign regfile_write_enable = wb_arm_r & clk_en;

endmodule

// File: tb/tb_core_seq.sv
// Directed self-checking bench for core_seq.
// Branch expectations follow CORE_SEQ_BRANCH_EN: taken targets when defined,
// pc+1 (NOP behaviour) otherwise.
module tb_core_seq;

`ifdef CORE_SEQ_BRANCH_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [3:0]  regfile_read_addr_a;
    logic [3:0]  regfile_read_addr_b;
    logic [7:0]  regfile_read_data_a;
    logic [3:0]  regfile_write_addr;
    logic        regfile_write_enable;
    logic [2:0]  alu_func;
    logic        alu_clk_en;
    logic [7:0]  pc;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] p1;
    logic [7:0] p2;
    logic [7:0] p3;

    always #5 clk = ~clk;

    core_seq dut (
        .clk                  (clk),
        .rst                  (rst),
        .clk_en               (clk_en),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_ack             (imem_ack),
        .imem_rdata           (imem_rdata),
        .regfile_read_addr_a  (regfile_read_addr_a),
        .regfile_read_addr_b  (regfile_read_addr_b),
        .regfile_read_data_a  (regfile_read_data_a),
        .regfile_write_addr   (regfile_write_addr),
        .regfile_write_enable (regfile_write_enable),
        .alu_func             (alu_func),
        .alu_clk_en           (alu_clk_en),
        .pc                   (pc),
        .halted               (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, ending 2 time units after the last edge
    task automatic adv(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Run one non-HALT instruction from FETCH back to the next FETCH
    task automatic run_instr(input logic [15:0] instr);
        imem_ack   = 1'b1;
        imem_rdata = instr;
        adv(1);
        imem_ack = 1'b0;
        adv(3);
    endtask

    initial begin
        p1 = BR ? 8'h40 : 8'd12;
        p2 = BR ? 8'h30 : 8'd13;
        p3 = BR ? 8'h31 : 8'd14;

        rst = 1'b1; clk_en = 1'b1; imem_ack = 1'b0;
        imem_rdata = 16'h0000; regfile_read_data_a = 8'd0;

        // Reset for two cycles
        adv(2);
        #1;
        check("rst_pc", pc, 32'd10);
        check("rst_req", imem_req, 32'd0);
        check("rst_halted", halted, 32'd0);
        check("rst_alu_en", alu_clk_en, 32'd0);
        check("rst_we", regfile_write_enable, 32'd0);
        check("rst_rda", regfile_read_addr_a, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_req0", imem_req, 32'd0);
        adv(1);
        check("fetch_req1", imem_req, 32'd1);
        check("fetch_addr10", imem_addr, 32'd10);

        // ALU 0x3125 after three wait cycles
        for (int i = 0; i < 3; i++) begin
            check("fetch_wait_req", imem_req, 32'd1);
            adv(1);
        end
        imem_ack = 1'b1; imem_rdata = 16'h3125;
        adv(1);
        imem_ack = 1'b0;
        #1;
        check("dec_req0", imem_req, 32'd0);
        check("dec_rda", regfile_read_addr_a, 32'd2);
        check("dec_rdb", regfile_read_addr_b, 32'd5);
        check("dec_alu_en0", alu_clk_en, 32'd0);
        adv(1);
        check("exec_alu_en", alu_clk_en, 32'd1);
        check("exec_func", alu_func, 32'd3);
        check("exec_rda", regfile_read_addr_a, 32'd2);
        check("exec_rdb", regfile_read_addr_b, 32'd5);
        check("exec_we0", regfile_write_enable, 32'd0);
        adv(1);
        check("wb_alu_en0", alu_clk_en, 32'd0);
        check("wb_we", regfile_write_enable, 32'd1);
        check("wb_waddr", regfile_write_addr, 32'd1);
        check("wb_pc_hold", pc, 32'd10);
        adv(1);
        check("alu_pc11", pc, 32'd11);
        check("alu_we0", regfile_write_enable, 32'd0);
        check("alu_next_addr", imem_addr, 32'd11);

        // Ack while clk_en low is ignored
        clk_en = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h0ABC;
        adv(2);
        check("stall_ack_req", imem_req, 32'd1);
        check("stall_ack_ir", regfile_read_addr_a, 32'd2);
        clk_en = 1'b1; imem_ack = 1'b0;
        adv(1);
        check("stall_ack_still_fetch", imem_req, 32'd1);

        // JMP 0x8040, with a stray ack in DECODE
        imem_ack = 1'b1; imem_rdata = 16'h8040;
        adv(1);
        imem_rdata = 16'h1111;
        adv(1);
        imem_ack = 1'b0;
        #1;
        check("jmp_ack_outside_fetch", regfile_read_addr_a, 32'd4);
        check("jmp_no_alu", alu_clk_en, 32'd0);
        adv(1);
        check("jmp_no_we", regfile_write_enable, 32'd0);
        adv(1);
        check("jmp_pc", pc, p1);
        check("jmp_addr", imem_addr, p1);

        // BEQZ taken (operand zero) and not taken (operand 5)
        regfile_read_data_a = 8'd0;
        run_instr(16'h9030);
        check("beqz_zero_pc", pc, p2);
        regfile_read_data_a = 8'd5;
        run_instr(16'h9030);
        check("beqz_nz_pc", pc, p3);
        regfile_read_data_a = 8'd0;

        // Stall four cycles in EXEC of ALU 0x7A9B
        imem_ack = 1'b1; imem_rdata = 16'h7A9B;
        adv(1);
        imem_ack = 1'b0;
        adv(1);
        clk_en = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("stall_alu_en0", alu_clk_en, 32'd0);
            check("stall_we0", regfile_write_enable, 32'd0);
            check("stall_pc", pc, p3);
            adv(1);
        end
        clk_en = 1'b1;
        #1;
        check("resume_alu_en", alu_clk_en, 32'd1);
        check("resume_func", alu_func, 32'd7);
        adv(1);
        check("resume_we", regfile_write_enable, 32'd1);
        check("resume_waddr", regfile_write_addr, 32'd10);
        check("resume_alu_en0", alu_clk_en, 32'd0);
        adv(1);
        check("resume_pc", pc, p3 + 8'd1);

        // Walk PC up to 255 with NOPs, then wrap
        for (int i = 0; i < 300 && pc != 8'hFF; i++) begin
            run_instr(16'hA000);
        end
        check("reach_255", pc, 32'hFF);
        run_instr(16'hA000);
        check("wrap_pc0", pc, 32'd0);
        check("wrap_addr0", imem_addr, 32'd0);
        check("wrap_req", imem_req, 32'd1);

        // Reset in the middle of FETCH
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
        #1;
        check("abort_pc", pc, 32'd10);
        check("abort_req0", imem_req, 32'd0);
        adv(1);
        check("abort_refetch_req", imem_req, 32'd1);
        check("abort_refetch_addr", imem_addr, 32'd10);

        // HALT is terminal
        imem_ack = 1'b1; imem_rdata = 16'hF000;
        adv(1);
        imem_ack = 1'b0;
        adv(1);
        check("halt_exec_no_alu", alu_clk_en, 32'd0);
        adv(1);
        check("halted", halted, 32'd1);
        for (int i = 0; i < 20; i++) begin
            imem_ack = i[0];
            adv(1);
            check("halt_req0", imem_req, 32'd0);
            check("halt_pc", pc, 32'd10);
            check("halt_stays", halted, 32'd1);
        end
        imem_ack = 1'b0;
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
        #1;
        check("halt_rst_clear", halted, 32'd0);
        check("halt_rst_pc", pc, 32'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
